// File: rtl/challenge_issuer.sv
// challenge_issuer: steps the LFSR, sends a 16-bit challenge over a byte
// stream and checks the two-byte response against challenge ^ KEY.
module challenge_issuer #(
  parameter logic [15:0] KEY            = 16'h5A5A,
  parameter int          ADVANCE_STEPS  = 1,
  parameter int          TIMEOUT_CYCLES = 12_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] lfsr_random,
  output logic        lfsr_enable,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] challenge,
  output logic        busy,
  output logic        pass,
  output logic        fail,
  output logic        auth_ok
);

  localparam int SW = (ADVANCE_STEPS > 1) ? $clog2(ADVANCE_STEPS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(ADVANCE_STEPS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ADVANCE, CAPTURE, SEND_HI,
    SEND_LO, WAIT_HI, WAIT_LO, CHECK
  } state_t;

  state_t state, state_n;

  logic [SW-1:0] step_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    resp_hi;
  logic          in_wait;
  logic          xfer;
  logic          rx_ok;
  logic          tmo_hit;
  logic          resp_ok;

  logic [15:0] chal_n;
  logic [7:0]  tx_data_n;
  logic        en_n;
  logic        txv_n;
  logic        busy_n;
  logic        pass_n;
  logic        fail_n;
  logic        auth_n;

  assign in_wait = (state == WAIT_HI) || (state == WAIT_LO);
  assign xfer    = tx_valid && tx_ready;
  // a byte counts only while the counter is still inside the budget
  assign rx_ok   = rx_valid && (tmo_cnt <= TMO_LAST);
  assign tmo_hit = tmo_cnt >= TMO_LAST;
  assign resp_ok = ({resp_hi, rx_data} == (challenge ^ KEY));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = ADVANCE;
      ADVANCE: if (step_cnt == '0) state_n = CAPTURE;
      CAPTURE: state_n = (lfsr_random == 16'h0) ? ADVANCE : SEND_HI;
      SEND_HI: if (xfer) state_n = SEND_LO;
      SEND_LO: if (xfer) state_n = WAIT_HI;
      WAIT_HI: begin
        if (rx_ok)        state_n = WAIT_LO;
        else if (tmo_hit) state_n = IDLE;
      end
      WAIT_LO: begin
        if (rx_ok)        state_n = CHECK;
        else if (tmo_hit) state_n = IDLE;
      end
      CHECK:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    chal_n = (state == CAPTURE) ? lfsr_random : challenge;
    en_n   = (state_n == ADVANCE);
    txv_n  = (state_n == SEND_HI) || (state_n == SEND_LO);
    busy_n = (state_n != IDLE);
    pass_n = (state == WAIT_LO) && rx_ok && resp_ok;
    fail_n = ((state == WAIT_LO) && rx_ok && !resp_ok) ||
             (in_wait && !rx_ok && tmo_hit);
    tx_data_n = tx_data;
    unique case (1'b1)
      (state_n == SEND_HI): tx_data_n = chal_n[15:8];
      (state_n == SEND_LO): tx_data_n = chal_n[7:0];
      default:              tx_data_n = tx_data;
    endcase
    auth_n = auth_ok;
    if ((state == IDLE) && start) auth_n = 1'b0;
    if (pass_n) auth_n = 1'b1;
    if (fail_n) auth_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_enable <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h0;
      challenge   <= 16'h0;
      busy        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      auth_ok     <= 1'b0;
      step_cnt    <= '0;
      tmo_cnt     <= '0;
      resp_hi     <= 8'h0;
    end else begin
      lfsr_enable <= en_n;
      tx_valid    <= txv_n;
      tx_data     <= tx_data_n;
      challenge   <= chal_n;
      busy        <= busy_n;
      pass        <= pass_n;
      fail        <= fail_n;
      auth_ok     <= auth_n;
      if ((state_n == ADVANCE) && (state != ADVANCE))
        step_cnt <= STEP_LAST;
      else if ((state == ADVANCE) && (step_cnt != '0))
        step_cnt <= step_cnt - SW'(1);
      tmo_cnt <= in_wait ? tmo_cnt + TW'(1) : '0;
      if ((state == WAIT_HI) && rx_valid)
        resp_hi <= rx_data;
    end
  end

endmodule

// File: tb/tb_challenge_issuer.sv
// tb_challenge_issuer: vector table, hand-written corner sequences and
// randomized attempts against a behavioural model of the protocol.
module tb_challenge_issuer;

  localparam int          ADV  = 1;
  localparam int          TMO  = 8;
  localparam logic [15:0] KEY  = 16'h5A5A;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] lfsr_random;
  logic        lfsr_enable;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic [15:0] challenge;
  logic        busy;
  logic        pass;
  logic        fail;
  logic        auth_ok;

  logic        lfsr_rst = 1'b1;
  logic [15:0] lfsr_q;
  logic        stub_en = 1'b0;
  logic [15:0] stub_val = 16'h0;
  logic [15:0] m_lfsr;
  bit          prev_auth;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  challenge_issuer #(
    .KEY(KEY),
    .ADVANCE_STEPS(ADV),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .lfsr_random(lfsr_random),
    .lfsr_enable(lfsr_enable),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .challenge(challenge),
    .busy(busy),
    .pass(pass),
    .fail(fail),
    .auth_ok(auth_ok)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always @(posedge clk) begin
    if (lfsr_rst)         lfsr_q <= SEED;
    else if (lfsr_enable) lfsr_q <= lfsr_next(lfsr_q);
  end

  assign lfsr_random = stub_en ? stub_val : lfsr_q;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic reseed();
    @(negedge clk);
    lfsr_rst = 1'b1;
    @(negedge clk);
    lfsr_rst = 1'b0;
    m_lfsr = SEED;
  endtask

  // model: the challenge is the first non-zero value after ADV steps
  function automatic logic [15:0] model_challenge();
    do begin
      for (int s = 0; s < ADV; s++) m_lfsr = lfsr_next(m_lfsr);
    end while (m_lfsr == 16'h0);
    return m_lfsr;
  endfunction

  task automatic attempt(input string tag, input logic [15:0] exp_chal,
                         input logic [7:0] b0, input logic [7:0] b1,
                         input int k0, input int k1, input int rdy,
                         input bit noise, input int exp_en,
                         input bit exp_auth0, input bit exp_ok,
                         input int exp_j);
    int c, ntx, npass, nfail, pj, en_cnt, first_tx, wstart, widx;
    int stall_left, both;
    bit busy_seen, done, prev_stall, rdy_v;
    logic [7:0]  prev_data;
    logic [15:0] word;
    c = 0; ntx = 0; npass = 0; nfail = 0; pj = -1; en_cnt = 0;
    first_tx = -1; wstart = -1; stall_left = rdy; both = 0;
    busy_seen = 0; done = 0; prev_stall = 0; prev_data = 8'h0;
    word = 16'h0;
    @(negedge clk);
    check({tag, "_auth_pre"}, auth_ok, exp_auth0);
    start = 1'b1;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    for (int g = 0; g < 300; g++) begin
      en_cnt += int'(lfsr_enable);
      if (stub_en && en_cnt > ADV) stub_val = 16'h1234;
      if (pass && fail) both++;
      if (pass || fail) begin
        if (pj < 0) pj = c - wstart;
        if (pass) npass++;
        if (fail) nfail++;
      end
      if (c == 1) check({tag, "_auth_clr"}, auth_ok, 1'b0);
      if (busy) busy_seen = 1;
      if (busy_seen && !busy) begin
        done = 1;
        break;
      end
      if (prev_stall) begin
        check({tag, "_txv_hold"}, tx_valid, 1'b1);
        check({tag, "_txd_hold"}, tx_data, prev_data);
      end
      if (rdy == 0) rdy_v = 1;
      else if (rdy > 0) rdy_v = !(tx_valid && stall_left > 0);
      else rdy_v = bit'($urandom_range(0, 1));
      if (rdy > 0 && tx_valid && stall_left > 0) stall_left--;
      tx_ready = rdy_v;
      if (tx_valid && first_tx < 0) first_tx = c;
      prev_stall = tx_valid && !rdy_v;
      prev_data = tx_data;
      if (tx_valid && rdy_v) begin
        word = {word[7:0], tx_data};
        ntx++;
        if (ntx == 2) wstart = c + 1;
      end
      rx_valid = 1'b0;
      rx_data = 8'($urandom);
      if (wstart >= 0 && c >= wstart) begin
        widx = c - wstart;
        if (widx == k0) begin
          rx_valid = 1'b1;
          rx_data = b0;
        end else if (widx == k1) begin
          rx_valid = 1'b1;
          rx_data = b1;
        end
      end else if (noise && busy) begin
        rx_valid = ($urandom_range(0, 3) == 0);
      end
      start = noise && busy && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    check({tag, "_finished"}, done, 1'b1);
    check({tag, "_ntx"}, ntx, 2);
    check({tag, "_txword"}, word, exp_chal);
    check({tag, "_chal"}, challenge, exp_chal);
    check({tag, "_en_cycles"}, en_cnt, exp_en);
    check({tag, "_npass"}, npass, exp_ok ? 1 : 0);
    check({tag, "_nfail"}, nfail, exp_ok ? 0 : 1);
    check({tag, "_pulse_at"}, pj, exp_j);
    check({tag, "_pf_excl"}, both, 0);
    check({tag, "_auth"}, auth_ok, exp_ok);
    if (rdy == 0 && exp_en == ADV)
      check({tag, "_first_txv"}, first_tx, 2 + ADV);
  endtask

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    int         k0;
    int         k1;
    int         rdy;
    bit         ok;
    int         j;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [15:0] ec;
    logic [15:0] good;
    logic [7:0]  r0, r1;
    int          k0, k1, jj;
    bit          ok;

    tbl[0] = '{8'h03, 8'h99, 0,   1,   0, 1'b1, 2};
    tbl[1] = '{8'h03, 8'h98, 0,   1,   0, 1'b0, 2};
    tbl[2] = '{8'h03, 8'h99, 0,   7,   0, 1'b1, 8};
    tbl[3] = '{8'h03, 8'h99, 100, 100, 0, 1'b0, 8};
    tbl[4] = '{8'h03, 8'h99, 0,   100, 0, 1'b0, 8};
    tbl[5] = '{8'h03, 8'h99, 7,   8,   0, 1'b0, 9};
    tbl[6] = '{8'h03, 8'h99, 3,   5,   5, 1'b1, 6};
    tbl[7] = '{8'h59, 8'hC3, 1,   2,   0, 1'b0, 3};
    tbl[8] = '{8'h02, 8'h99, 0,   1,   0, 1'b0, 2};
    tbl[9] = '{8'h03, 8'h99, 6,   7,   0, 1'b1, 8};

    repeat (3) @(negedge clk);
    check("rst_en", lfsr_enable, 1'b0);
    check("rst_txv", tx_valid, 1'b0);
    check("rst_txd", tx_data, 8'h0);
    check("rst_chal", challenge, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_pf", {pass, fail}, 2'b00);
    check("rst_auth", auth_ok, 1'b0);
    rst = 1'b0;
    lfsr_rst = 1'b0;
    m_lfsr = SEED;
    prev_auth = 0;

    foreach (tbl[i]) begin
      reseed();
      attempt($sformatf("vec%0d", i), 16'h59C3, tbl[i].b0, tbl[i].b1,
              tbl[i].k0, tbl[i].k1, tbl[i].rdy, 1'b0, ADV,
              prev_auth, tbl[i].ok, tbl[i].j);
      prev_auth = tbl[i].ok;
    end

    // reset while SEND_LO is stalled; stray rx/start during SEND_HI
    reseed();
    @(negedge clk);
    start = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rs_en", lfsr_enable, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("rs_txv_hi", tx_valid, 1'b1);
    check("rs_txd_hi", tx_data, 8'h59);
    rx_valid = 1'b1;
    rx_data = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    start = 1'b0;
    tx_ready = 1'b0;
    check("rs_txd_lo", tx_data, 8'hC3);
    @(negedge clk);
    check("rs_txv_stall", tx_valid, 1'b1);
    check("rs_txd_stall", tx_data, 8'hC3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tx_ready = 1'b1;
    check("rs_outs", {lfsr_enable, tx_valid, busy, pass, fail, auth_ok},
          6'b0);
    check("rs_txd", tx_data, 8'h0);
    check("rs_chal", challenge, 16'h0);
    m_lfsr = SEED;
    void'(model_challenge());
    ec = model_challenge();
    good = ec ^ KEY;
    attempt("post_rst", ec, good[15:8], good[7:0], 0, 1, 0, 1'b0, ADV,
            1'b0, 1'b1, 2);

    // a zero capture forces a second advance burst
    stub_en = 1'b1;
    stub_val = 16'h0;
    attempt("stub", 16'h1234, 8'h48, 8'h6E, 1, 2, 0, 1'b0, 2 * ADV,
            1'b1, 1'b1, 3);
    stub_en = 1'b0;
    reseed();

    prev_auth = 1;
    for (int n = 0; n < 40; n++) begin
      ec = model_challenge();
      good = ec ^ KEY;
      if ($urandom_range(0, 1) == 1) begin
        r0 = good[15:8];
        r1 = good[7:0];
      end else begin
        r0 = 8'($urandom);
        r1 = 8'($urandom);
      end
      k0 = ($urandom_range(0, 4) == 0) ? $urandom_range(6, 9)
                                       : $urandom_range(0, 3);
      k1 = k0 + 1 + (($urandom_range(0, 3) == 0) ? $urandom_range(3, 8)
                                                 : $urandom_range(0, 2));
      if (k0 > TMO - 1)      jj = TMO;
      else if (k1 > TMO - 1) jj = (k0 + 2 > TMO) ? k0 + 2 : TMO;
      else                   jj = k1 + 1;
      ok = (k0 <= TMO - 1) && (k1 <= TMO - 1) && ({r0, r1} == good);
      attempt($sformatf("rnd%0d", n), ec, r0, r1, k0, k1, -1, 1'b1, ADV,
              prev_auth, ok, jj);
      prev_auth = ok;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/challenge_issuer.md
# challenge_issuer

Challenge-response sequencer sitting directly downstream of the 16-bit challenge LFSR. On `start` it:
- steps the LFSR;
- captures a non-zero 16-bit challenge;
- transmits it as two bytes over a valid/ready byte stream (UART TX side);
- collects a two-byte response from the RX byte strobe;
- checks the response against `challenge ^ KEY` within a cycle budget.

It reports pass/fail pulses and a sticky authenticated flag to the top-level lock logic.

## Interface
- `KEY`, 16'h5A5A, shared secret; expected response = `challenge ^ KEY`
- `ADVANCE_STEPS`, 1, consecutive cycles of `lfsr_enable` per attempt (≥1)
- `TIMEOUT_CYCLES`, 12_000_000, cycle budget from entering WAIT_HI to receiving the second response byte (≥2)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  begin an attempt; honoured only in IDLE
- `lfsr_random`  in  16  current LFSR value
- `lfsr_enable`  out  1  LFSR step request
- `tx_data`  out  8  byte to transmit
- `tx_valid`  out  1  `tx_data` valid
- `tx_ready`  in  1  transmitter accepts byte this cycle
- `rx_data`  in  8  received byte
- `rx_valid`  in  1  one-cycle strobe, `rx_data` valid; no backpressure
- `challenge`  out  16  last captured challenge
- `busy`  out  1  high in every state except IDLE
- `pass`  out  1  one-cycle pulse, response correct
- `fail`  out  1  one-cycle pulse, response wrong or timed out
- `auth_ok`  out  1  sticky; set on pass, cleared on fail, on accepted `start`, and on reset

## Operation
- States: IDLE, ADVANCE, CAPTURE, SEND_HI, SEND_LO, WAIT_HI, WAIT_LO, CHECK.
- IDLE → ADVANCE on `start`.
- ADVANCE:
  - `lfsr_enable` = 1 for exactly `ADVANCE_STEPS` cycles (down-counter), then → CAPTURE.
  - `lfsr_enable` is 0 in all other states.
- CAPTURE:
  - Register `challenge <= lfsr_random`.
  - If `lfsr_random == 0`, → ADVANCE again for another `ADVANCE_STEPS`; else → SEND_HI.
- SEND_HI:
  - `tx_valid` = 1, `tx_data = challenge[15:8]`.
  - Byte is transferred on a cycle with `tx_valid && tx_ready`; then → SEND_LO.
- SEND_LO: same handshake with `challenge[7:0]`; on transfer → WAIT_HI and clear the timeout counter.
- TX rules:
  - `tx_data` is stable while `tx_valid` is high and `tx_ready` is low.
  - `tx_valid` is never withdrawn before transfer, except by reset.
- WAIT_HI: on `rx_valid`, store `resp[15:8] = rx_data` → WAIT_LO.
- WAIT_LO: on `rx_valid`, store `resp[7:0] = rx_data` → CHECK.
- Timeout:
  - One counter spans both wait states and increments every cycle in them.
  - If the counter reaches `TIMEOUT_CYCLES-1` with no completing byte, the next state is IDLE with a `fail` pulse.
  - An `rx_valid` byte on the final counted cycle is accepted and wins over the timeout.
- CHECK (1 cycle):
  - If `resp == challenge ^ KEY`, `pass` = 1 and `auth_ok` is set.
  - Otherwise `fail` = 1 and `auth_ok` is cleared.
  - → IDLE.
- Ignored inputs:
  - `rx_valid` outside WAIT_HI/WAIT_LO, including during transmission.
  - `start` while `busy`.
- Counter width: `$clog2(TIMEOUT_CYCLES+1)`. Comparisons are full 16-bit.

## Timing
- Reset values (next edge after `rst`=1, any state):
  - State IDLE.
  - `lfsr_enable`, `tx_valid`, `busy`, `pass`, `fail`, `auth_ok` = 0.
  - `tx_data`, `challenge` = 0.
  - Timeout and step counters = 0.
- Reset mid-transfer drops `tx_valid` at that edge; no partial attempt resumes.
- `start` sampled at edge E:
  - ADVANCE occupies cycles E+1 … E+`ADVANCE_STEPS`.
  - CAPTURE is at E+`ADVANCE_STEPS`+1 and sees the fully stepped LFSR.
- With `tx_ready` tied high:
  - SEND_HI and SEND_LO take one cycle each.
  - First `tx_valid` appears 2+`ADVANCE_STEPS` cycles after `start`.
- All outputs are registered.
- `pass`/`fail` are asserted during the CHECK cycle (or the timeout-exit cycle) only.
- `pass` and `fail` are never high together.

## Test plan
- Real LFSR (seed 16'hACE1), `ADVANCE_STEPS`=1, `tx_ready`=1, `start` pulse:
  - `challenge` = 16'h59C3.
  - TX bytes 8'h59 then 8'hC3.
  - RX 8'h03, 8'h99 → one `pass` pulse; `auth_ok`=1.
- Same setup, RX 8'h03, 8'h98 → one `fail` pulse; `auth_ok` goes 1→0 when run after the passing case.
- `tx_ready` held low 5 cycles during SEND_HI → `tx_valid`=1 and `tx_data`=8'h59 stable for all 5 cycles; exactly one byte transferred.
- Timeout, `TIMEOUT_CYCLES`=8:
  - Send only 8'h03 → `fail` 8 cycles after entering WAIT_HI, then IDLE.
  - Repeat with the second byte arriving on the 8th cycle → `pass`.
- Stub `lfsr_random` = 0 for the first CAPTURE, 16'h1234 afterwards → second ADVANCE burst; challenge bytes 8'h12, 8'h34.
- Assert `rst` during SEND_LO with `tx_ready`=0 → next cycle all outputs zero, IDLE; a later `start` runs a clean attempt. `rx_valid` and `start` pulses during SEND_HI are ignored.
